// File: rtl/rv32i_multicycle_control.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXE plus MEM/WB for loads and stores.
// Qualifies datapath strobes per state, with a bus-ready handshake and timeout abort.
module rv32i_multicycle_control #(
  parameter int BUS_WAIT_MAX = 15,
  parameter int WAIT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        pcEn,
  output logic        irEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic        busWe,
  output logic        busRe,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        illegalInstr,
  output logic        busErr
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH, DECODE,
    EXE_R, EXE_I, EXE_LU, EXE_AU, EXE_J, EXE_JL, EXE_B,
    S_EXE, S_MEM, L_EXE, L_MEM, L_WB
  } state_t;

  state_t state, next;
  logic [WAIT_W-1:0] waitCnt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic inMem;
  logic timeout;

  assign opcode = instrCode[6:0];
  assign funct3 = instrCode[14:12];
  assign inMem  = (state == S_MEM) || (state == L_MEM);

  // busReady in the same cycle overrides the abort
  assign timeout = (BUS_WAIT_MAX != 0) && inMem && !busReady &&
                   (waitCnt == WAIT_W'(BUS_WAIT_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      waitCnt <= '0;
    end else begin
      state <= next;
      if (!inMem)
        waitCnt <= '0;
      else if (!busReady && !timeout)
        waitCnt <= waitCnt + 1'b1;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      FETCH: next = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:    next = EXE_R;
          OP_I:    next = EXE_I;
          OP_LU:   next = EXE_LU;
          OP_AU:   next = EXE_AU;
          OP_J:    next = EXE_J;
          OP_JL:   next = EXE_JL;
          OP_B:    next = EXE_B;
          OP_S:    next = S_EXE;
          OP_L:    next = L_EXE;
          default: next = FETCH;
        endcase
      end
      EXE_R, EXE_I, EXE_LU, EXE_AU,
      EXE_J, EXE_JL, EXE_B: next = FETCH;
      S_EXE: next = S_MEM;
      S_MEM: if (busReady || timeout) next = FETCH;
      L_EXE: next = L_MEM;
      L_MEM: begin
        if (busReady)     next = L_WB;
        else if (timeout) next = FETCH;
      end
      L_WB: next = FETCH;
      default: next = FETCH;
    endcase
  end

  always_comb begin
    aluControl = 4'b0000;
    if (!reset) begin
      case (opcode)
        OP_R, OP_B: aluControl = {instrCode[30], funct3};
        OP_I: aluControl = ({instrCode[30], funct3} == 4'b1101) ?
                           4'b1101 : {1'b0, funct3};
        default: aluControl = 4'b0000;
      endcase
    end
  end

  always_comb begin
    pcEn          = 1'b0;
    irEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    busWe         = 1'b0;
    busRe         = 1'b0;
    RFWDSrcMuxSel = 3'b000;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    illegalInstr  = 1'b0;
    busErr        = 1'b0;
    unique case (state)
      FETCH: irEn = 1'b1;
      DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_L, OP_S, OP_B,
          OP_LU, OP_AU, OP_J, OP_JL: ;
          default: begin
            illegalInstr = 1'b1;
            pcEn         = 1'b1;
          end
        endcase
      end
      EXE_R: begin
        pcEn      = 1'b1;
        regFileWe = 1'b1;
      end
      EXE_I: begin
        pcEn         = 1'b1;
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
      end
      EXE_LU: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b010;
      end
      EXE_AU: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b011;
      end
      EXE_J: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        jal           = 1'b1;
      end
      EXE_JL: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        jal           = 1'b1;
        jalr          = 1'b1;
      end
      EXE_B: begin
        pcEn   = 1'b1;
        branch = 1'b1;
      end
      S_EXE, L_EXE: aluSrcMuxSel = 1'b1;
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
        pcEn         = busReady || timeout;
        busErr       = timeout;
      end
      L_MEM: begin
        aluSrcMuxSel = 1'b1;
        busRe        = 1'b1;
        pcEn         = timeout;
        busErr       = timeout;
      end
      L_WB: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b001;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Directed bench for rv32i_multicycle_control.
// Expected strobe vectors queue up as stimulus is driven and are checked per cycle.
module tb_rv32i_multicycle_control;

  logic        clk;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        pcEn, irEn, regFileWe, aluSrcMuxSel;
  logic        busWe, busRe, branch, jal, jalr;
  logic        illegalInstr, busErr;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic [17:0] obs;

  int ncmp = 0;
  int nerr = 0;
  logic [17:0] sbq[$];
  string       tq[$];

  rv32i_multicycle_control #(.BUS_WAIT_MAX(15), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode),
    .busReady(busReady), .pcEn(pcEn), .irEn(irEn),
    .regFileWe(regFileWe), .aluControl(aluControl),
    .aluSrcMuxSel(aluSrcMuxSel), .busWe(busWe), .busRe(busRe),
    .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch), .jal(jal),
    .jalr(jalr), .illegalInstr(illegalInstr), .busErr(busErr)
  );

  assign obs = {pcEn, irEn, regFileWe, aluControl, aluSrcMuxSel,
                busWe, busRe, RFWDSrcMuxSel, branch, jal, jalr,
                illegalInstr, busErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(
    input logic pc, input logic ir, input logic we,
    input logic [3:0] alu, input logic src, input logic bwe,
    input logic bre, input logic [2:0] rf, input logic br,
    input logic j, input logic jr, input logic ill,
    input logic err);
    return {pc, ir, we, alu, src, bwe, bre, rf, br, j, jr, ill, err};
  endfunction

  task automatic push(input string tag, input logic [17:0] e);
    sbq.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic chk();
    logic [17:0] e;
    string t;
    e = sbq.pop_front();
    t = tq.pop_front();
    ncmp++;
    assert (obs === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic cyc(input string tag, input logic [17:0] e);
    push(tag, e);
    #2;
    chk();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] vRst, vDec, vSExe, vSMem, vLMem;

  initial begin
    vRst  = mk(0,1,0,4'h0,0,0,0,3'b000,0,0,0,0,0);
    vDec  = mk(0,0,0,4'h0,0,0,0,3'b000,0,0,0,0,0);
    vSExe = mk(0,0,0,4'h0,1,0,0,3'b000,0,0,0,0,0);
    vSMem = mk(0,0,0,4'h0,1,1,0,3'b000,0,0,0,0,0);
    vLMem = mk(0,0,0,4'h0,1,0,1,3'b000,0,0,0,0,0);

    reset = 1'b1;
    instrCode = 32'h002081B3;
    busReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push("reset", vRst);
    chk();
    reset = 1'b0;

    // ADD x3,x1,x2
    cyc("add_fetch", vRst);
    cyc("add_dec", vDec);
    cyc("add_exe", mk(1,0,1,4'h0,0,0,0,3'b000,0,0,0,0,0));

    // SRAI / SRLI
    instrCode = 32'h4032D293;
    cyc("srai_fetch", mk(0,1,0,4'hD,0,0,0,3'b000,0,0,0,0,0));
    cyc("srai_dec", mk(0,0,0,4'hD,0,0,0,3'b000,0,0,0,0,0));
    cyc("srai_exe", mk(1,0,1,4'hD,1,0,0,3'b000,0,0,0,0,0));
    instrCode = 32'h0032D293;
    cyc("srli_fetch", mk(0,1,0,4'h5,0,0,0,3'b000,0,0,0,0,0));
    cyc("srli_dec", mk(0,0,0,4'h5,0,0,0,3'b000,0,0,0,0,0));
    cyc("srli_exe", mk(1,0,1,4'h5,1,0,0,3'b000,0,0,0,0,0));

    // LW x4,0(x1), ready on third MEM cycle
    instrCode = 32'h0000A203;
    cyc("lw_fetch", vRst);
    cyc("lw_dec", vDec);
    cyc("lw_exe", vSExe);
    cyc("lw_mem0", vLMem);
    cyc("lw_mem1", vLMem);
    busReady = 1'b1;
    cyc("lw_mem2", vLMem);
    busReady = 1'b0;
    cyc("lw_wb", mk(1,0,1,4'h0,0,0,0,3'b001,0,0,0,0,0));

    // SW x2,4(x1), bus never ready
    instrCode = 32'h0020A223;
    cyc("sw_fetch", vRst);
    cyc("sw_dec", vDec);
    cyc("sw_exe", vSExe);
    for (int i = 0; i < 15; i++) cyc("sw_wait", vSMem);
    cyc("sw_timeout", mk(1,0,0,4'h0,1,1,0,3'b000,0,0,0,0,1));
    cyc("sw_after", vRst);

    // SW with ready on first MEM cycle
    cyc("sw0_dec", vDec);
    cyc("sw0_exe", vSExe);
    busReady = 1'b1;
    cyc("sw0_mem", mk(1,0,0,4'h0,1,1,0,3'b000,0,0,0,0,0));
    busReady = 1'b0;

    // LW with ready arriving exactly at the timeout cycle
    instrCode = 32'h0000A203;
    cyc("lwt_fetch", vRst);
    cyc("lwt_dec", vDec);
    cyc("lwt_exe", vSExe);
    for (int i = 0; i < 15; i++) cyc("lwt_wait", vLMem);
    busReady = 1'b1;
    cyc("lwt_ready", vLMem);
    busReady = 1'b0;
    cyc("lwt_wb", mk(1,0,1,4'h0,0,0,0,3'b001,0,0,0,0,0));

    // illegal opcode
    instrCode = 32'h0000007F;
    cyc("ill_fetch", vRst);
    cyc("ill_dec", mk(1,0,0,4'h0,0,0,0,3'b000,0,0,0,1,0));

    // JALR with busReady high (ignored outside MEM)
    instrCode = 32'h000080E7;
    busReady = 1'b1;
    cyc("jalr_fetch", vRst);
    cyc("jalr_dec", vDec);
    cyc("jalr_exe", mk(1,0,1,4'h0,0,0,0,3'b100,0,1,1,0,0));
    busReady = 1'b0;

    // BNE and LUI
    instrCode = 32'h00209463;
    cyc("bne_fetch", mk(0,1,0,4'h1,0,0,0,3'b000,0,0,0,0,0));
    cyc("bne_dec", mk(0,0,0,4'h1,0,0,0,3'b000,0,0,0,0,0));
    cyc("bne_exe", mk(1,0,0,4'h1,0,0,0,3'b000,1,0,0,0,0));
    instrCode = 32'h123450B7;
    cyc("lui_fetch", vRst);
    cyc("lui_dec", vDec);
    cyc("lui_exe", mk(1,0,1,4'h0,0,0,0,3'b010,0,0,0,0,0));

    // reset mid L_MEM
    instrCode = 32'h0000A203;
    cyc("lrst_fetch", vRst);
    cyc("lrst_dec", vDec);
    cyc("lrst_exe", vSExe);
    #2;
    push("lrst_mem", vLMem);
    chk();
    reset = 1'b1;
    #1;
    push("lrst_async", vRst);
    chk();
    @(posedge clk);
    #1;
    push("lrst_hold", vRst);
    chk();
    reset = 1'b0;

    // reset mid S_MEM
    instrCode = 32'h0020A223;
    cyc("srst_fetch", vRst);
    cyc("srst_dec", vDec);
    cyc("srst_exe", vSExe);
    #2;
    push("srst_mem", vSMem);
    chk();
    reset = 1'b1;
    #1;
    push("srst_async", vRst);
    chk();
    @(posedge clk);
    #1;
    push("srst_hold", vRst);
    chk();
    reset = 1'b0;

    // normal operation resumes
    instrCode = 32'h002081B3;
    cyc("post_fetch", vRst);
    cyc("post_dec", vDec);
    cyc("post_exe", mk(1,0,1,4'h0,0,0,0,3'b000,0,0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
